// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: shares the single register-file write port (WE3/AD3/WD3)
// between the ALU/execute source (A) and the late load/memory source (B).
// Each source owns a one-entry holding slot with a valid/ready handshake.
// Fixed priority favours A, with a starvation guard for B and an age bit
// that keeps same-register writes in acceptance order. pend_mask exposes
// every register with a write that has not yet reached the register file.
module reg_wb_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            a_valid,
  output logic                            a_ready,
  input  logic [ADDRESS_WIDTH-1:0]        a_rd,
  input  logic [DATA_WIDTH-1:0]           a_data,
  input  logic                            b_valid,
  output logic                            b_ready,
  input  logic [ADDRESS_WIDTH-1:0]        b_rd,
  input  logic [DATA_WIDTH-1:0]           b_data,
  output logic                            WE3,
  output logic [ADDRESS_WIDTH-1:0]        AD3,
  output logic [DATA_WIDTH-1:0]           WD3,
  output logic [(2**ADDRESS_WIDTH)-1:0]   pend_mask
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

  // Slot A
  logic                     a_vld_q, a_vld_d;
  logic [ADDRESS_WIDTH-1:0] a_rd_q, a_rd_d;
  logic [DATA_WIDTH-1:0]    a_data_q, a_data_d;
  // Slot B
  logic                     b_vld_q, b_vld_d;
  logic [ADDRESS_WIDTH-1:0] b_rd_q, b_rd_d;
  logic [DATA_WIDTH-1:0]    b_data_q, b_data_d;
  // Arbitration state
  logic                     b_older_q, b_older_d;
  logic [3:0]               b_wait_q, b_wait_d;
  // Registered write port
  logic                     we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
  logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;

  logic grant_a, grant_b;
  logic a_fill, b_fill;
  logic a_stay, b_stay;

  // Grant selection from the current slot state
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_vld_q && b_vld_q) begin
      if (a_rd_q == b_rd_q) begin
        // Same destination: oldest write must land first
        grant_b = b_older_q;
        grant_a = ~b_older_q;
      end else if (b_wait_q >= StarveLim) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else begin
      grant_a = a_vld_q;
      grant_b = b_vld_q;
    end
  end

  assign a_ready = rst_n & (~a_vld_q | grant_a);
  assign b_ready = rst_n & (~b_vld_q | grant_b);

  // Writes to x0 complete the handshake but are never stored
  assign a_fill = a_valid & a_ready & (a_rd != '0);
  assign b_fill = b_valid & b_ready & (b_rd != '0);

  // A slot "stays" when it holds an entry that loses arbitration this cycle
  assign a_stay = a_vld_q & ~grant_a;
  assign b_stay = b_vld_q & ~grant_b;

  // Next-state for slots, age bit, starvation counter and write port
  always_comb begin
    a_vld_d  = a_fill | a_stay;
    a_rd_d   = a_fill ? a_rd : a_rd_q;
    a_data_d = a_fill ? a_data : a_data_q;

    b_vld_d  = b_fill | b_stay;
    b_rd_d   = b_fill ? b_rd : b_rd_q;
    b_data_d = b_fill ? b_data : b_data_q;

    // A new entry is younger than whatever entry survives in the other slot;
    // simultaneous fills make B the older one.
    b_older_d = b_older_q;
    if (b_fill) begin
      b_older_d = ~a_stay;
    end else if (a_fill) begin
      b_older_d = b_stay;
    end

    if (b_stay) begin
      b_wait_d = (b_wait_q < StarveLim) ? 4'(b_wait_q + 4'd1) : b_wait_q;
    end else begin
      b_wait_d = 4'd0;
    end

    we3_d = grant_a | grant_b;
    ad3_d = ad3_q;
    wd3_d = wd3_q;
    if (grant_b) begin
      ad3_d = b_rd_q;
      wd3_d = b_data_q;
    end else if (grant_a) begin
      ad3_d = a_rd_q;
      wd3_d = a_data_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_vld_q   <= 1'b0;
      a_rd_q    <= '0;
      a_data_q  <= '0;
      b_vld_q   <= 1'b0;
      b_rd_q    <= '0;
      b_data_q  <= '0;
      b_older_q <= 1'b0;
      b_wait_q  <= 4'd0;
      we3_q     <= 1'b0;
      ad3_q     <= '0;
      wd3_q     <= '0;
    end else begin
      a_vld_q   <= a_vld_d;
      a_rd_q    <= a_rd_d;
      a_data_q  <= a_data_d;
      b_vld_q   <= b_vld_d;
      b_rd_q    <= b_rd_d;
      b_data_q  <= b_data_d;
      b_older_q <= b_older_d;
      b_wait_q  <= b_wait_d;
      we3_q     <= we3_d;
      ad3_q     <= ad3_d;
      wd3_q     <= wd3_d;
    end
  end

  assign WE3 = we3_q;
  assign AD3 = ad3_q;
  assign WD3 = wd3_q;

  // Pending-write mask: both slots plus the write currently on the port
  always_comb begin
    pend_mask = '0;
    if (a_vld_q) pend_mask[a_rd_q] = 1'b1;
    if (b_vld_q) pend_mask[b_rd_q] = 1'b1;
    if (we3_q)   pend_mask[ad3_q]  = 1'b1;
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed cycle-exact scenarios followed by random
// traffic checked against a per-register ordering scoreboard.
module tb_reg_wb_arbiter;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [AW-1:0] a_rd = '0;
  logic [DW-1:0] a_data = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [AW-1:0] b_rd = '0;
  logic [DW-1:0] b_data = '0;
  logic          WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;
  logic [NREG-1:0] pend_mask;

  always #5 clk = ~clk;

  reg_wb_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_rd     (a_rd),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_rd     (b_rd),
    .b_data   (b_data),
    .WE3      (WE3),
    .AD3      (AD3),
    .WD3      (WD3),
    .pend_mask(pend_mask)
  );

  int n_vec = 0;
  int n_err = 0;

  // Outstanding accepted writes, in acceptance order
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;
  wr_t sb[$];

  int  exp_ad [6] = '{1, 2, 3, 4, 9, 5};
  logic acc;
  bit  aa, ab;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREG-1:0] bit_of(input int r);
    logic [NREG-1:0] m;
    m = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  // One scoreboard cycle: check mask and commit, then record this cycle's accepts
  task automatic sb_cycle(output bit acc_a, output bit acc_b);
    logic [NREG-1:0] exp_mask;
    int idx;
    @(negedge clk);
    exp_mask = '0;
    for (int i = 0; i < sb.size(); i++) exp_mask[sb[i].rd] = 1'b1;
    exp_mask[0] = 1'b0;
    check_eq("rnd_pend_mask", 64'(pend_mask), 64'(exp_mask));
    if (WE3) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (idx < 0 && sb[i].rd == AD3) idx = i;
      end
      check_eq("rnd_we3_outstanding", 64'(idx >= 0), 64'(1));
      if (idx >= 0) begin
        check_eq("rnd_wd3_order", 64'(WD3), 64'(sb[idx].data));
        sb.delete(idx);
      end
    end
    acc_a = a_valid & a_ready;
    acc_b = b_valid & b_ready;
    // Simultaneous accepts: B counts as the older write
    if (acc_b && b_rd != '0) sb.push_back('{rd: b_rd, data: b_data});
    if (acc_a && a_rd != '0) sb.push_back('{rd: a_rd, data: a_data});
  endtask

  initial begin
    // Reset held with A requesting
    a_valid = 1'b1;
    a_rd    = 5'd3;
    a_data  = 32'h0000_0333;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_a_ready", 64'(a_ready), 64'(0));
      check_eq("rst_we3", 64'(WE3), 64'(0));
      check_eq("rst_ad3", 64'(AD3), 64'(0));
      check_eq("rst_pend", 64'(pend_mask), 64'(0));
    end
    rst_n   = 1'b1;
    a_valid = 1'b0;
    #1;
    check_eq("rel_a_ready", 64'(a_ready), 64'(1));
    tick();

    // Single write from A
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("sw_a_ready", 64'(a_ready), 64'(1));
    check_eq("sw_pend0", 64'(pend_mask), 64'(0));
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check_eq("sw_we3_early", 64'(WE3), 64'(0));
    check_eq("sw_pend1", 64'(pend_mask), 64'(bit_of(5)));
    tick();
    @(negedge clk);
    check_eq("sw_we3", 64'(WE3), 64'(1));
    check_eq("sw_ad3", 64'(AD3), 64'(5));
    check_eq("sw_wd3", 64'(WD3), 64'(32'hDEAD_BEEF));
    check_eq("sw_pend2", 64'(pend_mask), 64'(bit_of(5)));
    tick();
    @(negedge clk);
    check_eq("sw_we3_off", 64'(WE3), 64'(0));
    check_eq("sw_pend3", 64'(pend_mask), 64'(0));
    tick();

    // x0 write is accepted and dropped
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h0000_1234;
    @(negedge clk);
    check_eq("x0_b_ready", 64'(b_ready), 64'(1));
    tick();
    b_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("x0_we3", 64'(WE3), 64'(0));
      check_eq("x0_pend", 64'(pend_mask), 64'(0));
      tick();
    end

    // Priority with starvation guard: A streams, B holds rd=9
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA000_0001;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h0900_0009;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_eq("stv_a_ready0", 64'(a_ready), 64'(1));
        check_eq("stv_b_ready0", 64'(b_ready), 64'(1));
      end
      if (c >= 1 && c <= 4) check_eq("stv_b_ready_wait", 64'(b_ready), 64'(0));
      if (c == 5) check_eq("stv_a_ready_blk", 64'(a_ready), 64'(0));
      if (c >= 2) begin
        check_eq("stv_we3", 64'(WE3), 64'(1));
        check_eq("stv_ad3", 64'(AD3), 64'(exp_ad[c-2]));
        if (exp_ad[c-2] == 9) check_eq("stv_wd3_b", 64'(WD3), 64'(32'h0900_0009));
        else check_eq("stv_wd3_a", 64'(WD3), 64'(32'hA000_0000 | 32'(exp_ad[c-2])));
      end
      acc = a_valid & a_ready;
      tick();
      if (c == 0) b_valid = 1'b0;
      if (acc) begin
        a_rd   = a_rd + 5'd1;
        a_data = 32'hA000_0000 | 32'(a_rd);
      end
    end
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Ordering: B accepts rd7 first, A one cycle later
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h11;
    @(negedge clk);
    check_eq("ord_b_ready", 64'(b_ready), 64'(1));
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h22;
    @(negedge clk);
    check_eq("ord_a_ready", 64'(a_ready), 64'(1));
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check_eq("ord_we3_1", 64'(WE3), 64'(1));
    check_eq("ord_ad3_1", 64'(AD3), 64'(7));
    check_eq("ord_wd3_1", 64'(WD3), 64'(32'h11));
    tick();
    @(negedge clk);
    check_eq("ord_we3_2", 64'(WE3), 64'(1));
    check_eq("ord_wd3_2", 64'(WD3), 64'(32'h22));
    tick();
    @(negedge clk);
    check_eq("ord_we3_off", 64'(WE3), 64'(0));
    tick();

    // Simultaneous same-rd accepts into empty slots: B is older
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h33;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h44;
    @(negedge clk);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check_eq("age_wd3_1", 64'(WD3), 64'(32'h44));
    tick();
    @(negedge clk);
    check_eq("age_wd3_2", 64'(WD3), 64'(32'h33));
    tick();
    tick();

    // Reset with both slots full
    a_valid = 1'b1; a_rd = 5'd10; a_data = 32'hAAAA;
    b_valid = 1'b1; b_rd = 5'd11; b_data = 32'hBBBB;
    @(negedge clk);
    tick();
    a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check_eq("mrst_pend_full", 64'(pend_mask), 64'(bit_of(10) | bit_of(11)));
    check_eq("mrst_a_ready", 64'(a_ready), 64'(0));
    check_eq("mrst_b_ready", 64'(b_ready), 64'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mrst_we3", 64'(WE3), 64'(0));
      check_eq("mrst_pend", 64'(pend_mask), 64'(0));
      tick();
    end

    // Random traffic against the ordering scoreboard
    for (int c = 0; c < 1500; c++) begin
      sb_cycle(aa, ab);
      tick();
      if (!a_valid || aa) begin
        a_valid = ($urandom_range(0, 99) < 70);
        a_rd    = AW'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      if (!b_valid || ab) begin
        b_valid = ($urandom_range(0, 99) < 50);
        b_rd    = AW'($urandom_range(0, 7));
        b_data  = $urandom;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sb_cycle(aa, ab);
      tick();
    end
    check_eq("drain_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
